// File: rtl/noc_pkg.sv
// Shared router constants: port numbering and default flit width.
package noc_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int FLIT_WIDTH = 288;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    // Index width for a round-robin pointer over n requesters.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotating-priority picker: first eligible index at or above rr_ptr, wrapping.
module rr_select #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] index,
    output logic             any
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [PTR_W:0] offset;
    logic [PTR_W:0] sum;

    // Rotating a doubled copy puts rr_ptr at bit 0, so a lowest-bit search gives the winner.
    assign doubled = {eligible, eligible} >> rr_ptr;
    assign rotated = doubled[N-1:0];

    always_comb begin
        offset = '0;
        any    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = (PTR_W + 1)'(k);
                any    = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, rr_ptr} + offset;
        if (sum >= (PTR_W + 1)'(N)) begin
            sum = sum - (PTR_W + 1)'(N);
        end
        index = sum[PTR_W-1:0];
        grant = any ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/noc_outport_arbiter.sv
// Output-port arbiter: picks one input per cycle round-robin into a registered output slot.
module noc_outport_arbiter
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int NUM_IN     = NUM_PORTS,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_IN-1:0]                  req_valid,
    output logic [NUM_IN-1:0]                  clear,
    input  logic [NUM_IN-1:0]                  port_mask,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CNT_WIDTH-1:0]               flit_count
);

    localparam int PTR_W = ptr_width(NUM_IN);

    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_valid_reg;
    logic [NUM_IN-1:0]     clear_reg;
    logic [PTR_W-1:0]      rr_ptr_reg;
    logic [CNT_WIDTH-1:0]  flit_count_reg;

    logic [NUM_IN-1:0]     eligible;
    logic [NUM_IN-1:0]     grant;
    logic [PTR_W-1:0]      win_index;
    logic                  win_any;
    logic                  slot_free;
    logic [PTR_W-1:0]      rr_ptr_next;

    // An input just cleared still shows its consumed flit on req_valid, so skip it.
    assign eligible  = req_valid & port_mask & ~clear_reg;
    assign slot_free = ~out_valid_reg | out_ready;

    rr_select #(
        .N     (NUM_IN),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_reg),
        .grant    (grant),
        .index    (win_index),
        .any      (win_any)
    );

    assign rr_ptr_next = (win_index == PTR_W'(NUM_IN - 1)) ? '0 : win_index + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            clear_reg      <= '0;
            rr_ptr_reg     <= '0;
            flit_count_reg <= '0;
        end else begin
            clear_reg <= '0;
            if (slot_free) begin
                if (win_any) begin
                    out_data_reg   <= req_data[win_index];
                    out_valid_reg  <= 1'b1;
                    clear_reg      <= grant;
                    rr_ptr_reg     <= rr_ptr_next;
                    flit_count_reg <= flit_count_reg + CNT_WIDTH'(1);
                end else begin
                    // Free slot with nothing to send: either drained or already empty.
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign clear      = clear_reg;
    assign flit_count = flit_count_reg;

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// Directed and random checks of noc_outport_arbiter against a round-robin reference model.
module tb_noc_outport_arbiter;

    localparam int DW = 288;
    localparam int N  = 5;
    localparam int CW = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0][DW-1:0]     req_data;
    logic [N-1:0]             req_valid;
    logic [N-1:0]             clear;
    logic [N-1:0]             port_mask;
    logic [DW-1:0]            out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CW-1:0]            flit_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_ptr;
    bit              m_valid;
    logic [DW-1:0]   m_data;
    logic [N-1:0]    m_clear;
    int unsigned     m_count;

    logic [DW-1:0]   saved;

    noc_outport_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_IN     (N),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .clear      (clear),
        .port_mask  (port_mask),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flit_count (flit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_flit();
        logic [DW-1:0] f;
        for (int w = 0; w < DW / 32; w++) f[w*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic randomize_data();
        for (int p = 0; p < N; p++) req_data[p] = rand_flit();
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_clear = '0; m_count = 0;
    endtask

    // One clock edge of the arbiter as described by its rules, from current inputs.
    task automatic model_edge();
        bit           free;
        logic [N-1:0] elig;
        int           win;
        free = !m_valid || out_ready;
        elig = req_valid & port_mask & ~m_clear;
        win  = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (win < 0 && elig[j]) win = j;
            end
        end
        m_clear = '0;
        if (win >= 0) begin
            m_data       = req_data[win];
            m_valid      = 1;
            m_clear[win] = 1'b1;
            m_ptr        = (win + 1) % N;
            m_count      = m_count + 1;
        end else if (free) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, DW'(out_valid), DW'(m_valid));
        chk({tag, ".data"},  out_data, m_data);
        chk({tag, ".clear"}, DW'(clear), DW'(m_clear));
        chk({tag, ".count"}, DW'(flit_count), DW'(m_count));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        $display("%s: req=%b mask=%b rdy=%b -> valid=%b clear=%b count=%0d",
                 tag, req_valid, port_mask, out_ready, out_valid, clear, flit_count);
        check_outputs(tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        port_mask = '1;
        out_ready = 1'b1;
        randomize_data();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", DW'(out_valid), '0);
        chk("reset.data",  out_data, '0);
        chk("reset.clear", DW'(clear), '0);
        chk("reset.count", DW'(flit_count), '0);
        rst = 1'b0;

        // Single request, granted on the first edge after reset release
        req_valid = 5'b00100;
        saved = req_data[2];
        step("single");
        chk("single.data_in2", out_data, saved);
        chk("single.clear_in2", DW'(clear), DW'(5'b00100));
        chk("single.count1", DW'(flit_count), DW'(1));
        req_valid = '0;
        step("single_idle");
        chk("single.clear_gone", DW'(clear), '0);

        // All five requesting: strict order 0,1,2,3,4,0
        pulse_reset();
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] exp_oh;
            randomize_data();
            exp_oh = N'(1) << (i % N);
            step("all5");
            chk("all5.order", DW'(clear), DW'(exp_oh));
        end

        // Backpressure holds the slot
        pulse_reset();
        randomize_data();
        req_valid = 5'b00010;
        saved = req_data[1];
        step("bp_grant1");
        out_ready = 1'b0;
        req_valid = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            randomize_data();
            step("bp_hold");
            chk("bp_hold.data", out_data, saved);
            chk("bp_hold.clear", DW'(clear), '0);
        end
        out_ready = 1'b1;
        saved = req_data[3];
        step("bp_release");
        chk("bp_release.data", out_data, saved);
        chk("bp_release.clear", DW'(clear), DW'(5'b01000));

        // Masking: only 0 and 4 may win
        req_valid = '1;
        port_mask = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            randomize_data();
            step("mask");
        end
        port_mask = '1;

        // Pointer wrap 4 -> 0
        pulse_reset();
        req_valid = 5'b01000;
        step("wrap_set");
        req_valid = 5'b10001;
        step("wrap4");
        chk("wrap.win4", DW'(clear), DW'(5'b10000));
        step("wrap0");
        chk("wrap.win0", DW'(clear), DW'(5'b00001));

        // Reset mid-operation while the slot is stalled
        req_valid = 5'b00100;
        out_ready = 1'b0;
        step("rst_mid_fill");
        step("rst_mid_stall");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid.valid", DW'(out_valid), '0);
        chk("rst_mid.clear", DW'(clear), '0);
        chk("rst_mid.count", DW'(flit_count), '0);
        chk("rst_mid.data",  out_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req_valid = '0;
        step("rst_mid_after");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            randomize_data();
            req_valid = N'($urandom);
            port_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_outport_arbiter.md
NOC_OUTPORT_ARBITER -- requirements
Module: noc_outport_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 288, meaning flit width including header.
REQ-002 SHALL have parameter NUM_IN, default 5, meaning requesting input ports (0 N, 1 E, 2 S, 3 W, 4 Local).
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning width of the forwarded-flit counter.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_data  input  NUM_IN x DATA_WIDTH  candidate flit from each input switch for this direction.
REQ-007 req_valid  input  NUM_IN  candidate valid per input switch.
REQ-008 clear  output  NUM_IN  one-cycle, one-hot consume pulse back to the granted input switch.
REQ-009 port_mask  input  NUM_IN  configuration: 1 = input enabled for arbitration.
REQ-010 out_data  output  DATA_WIDTH  registered flit to downstream link.
REQ-011 out_valid  output  1  out_data holds a flit.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 flit_count  output  CNT_WIDTH  total flits granted since reset.

Function
REQ-014 Output slot is free in a cycle when out_valid=0 or out_ready=1.
REQ-015 Eligible inputs SHALL be req_valid & port_mask & ~clear; an input whose clear is high this cycle SHALL NOT be eligible (its req_valid is stale).
REQ-016 When the slot is free and eligible is nonzero, winner SHALL be the first eligible index scanning upward from rr_ptr, wrapping 4->0 (NUM_IN-1 -> 0).
REQ-017 On a grant at edge t: out_data <= req_data[winner], out_valid <= 1, clear <= one-hot(winner), rr_ptr <= winner+1 modulo NUM_IN, flit_count <= flit_count+1.
REQ-018 Grant latency: request visible in cycle t -> out_valid and clear high in cycle t+1.
REQ-019 clear SHALL be high for exactly one cycle per grant and SHALL be all-zero in every cycle without a preceding grant.
REQ-020 Slot free and no eligible input: out_valid <= 0 if out_ready=1, otherwise hold; clear <= 0; rr_ptr and flit_count hold.
REQ-021 Slot not free (out_valid=1, out_ready=0): out_data, out_valid, rr_ptr and flit_count SHALL hold; clear <= 0; no grant.
REQ-022 Simultaneous drain and grant (out_valid=1, out_ready=1, eligible nonzero) SHALL replace out_data in the same edge: full throughput of one flit per cycle across different inputs.
REQ-023 A single input SHALL receive at most one grant every two cycles, as a consequence of REQ-015.
REQ-024 port_mask changes SHALL take effect in the same cycle; a flit already in out_data SHALL be delivered regardless of mask.
REQ-025 flit_count SHALL wrap modulo 2^CNT_WIDTH without saturation.
REQ-026 out_data SHALL NOT change while out_valid=1 and out_ready=0.

Reset
REQ-027 On rst: out_valid=0, out_data=0, clear=0, rr_ptr=0, flit_count=0, asynchronously and independent of clk.
REQ-028 A flit held in out_data when rst asserts SHALL be discarded; no clear SHALL be issued for it after reset.
REQ-029 First grant after rst release SHALL be possible on the first clk edge with rst low.

Structure
REQ-030 Shared package noc_pkg SHALL hold NUM_PORTS=5, port index constants (PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_L=4) and default DATA_WIDTH.
REQ-031 Rotating-priority selection SHALL be a combinational sub-module rr_select (inputs eligible, rr_ptr; outputs one-hot grant, encoded index, any).
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 Single request: req_valid=5'b00100, port_mask=5'b11111, out_ready=1 -> cycle+1 out_valid=1, out_data=req_data[2], clear=5'b00100 for 1 cycle, flit_count=1.
REQ-034 All five request continuously, out_ready=1, rr_ptr=0 -> grant order 0,1,2,3,4,0; clear one-hot each cycle; no input granted twice in consecutive cycles.
REQ-035 Backpressure: grant input 1, hold out_ready=0 for 4 cycles while input 3 requests -> out_data stays req_data[1], clear=0, no grant; out_ready=1 -> next edge out_data=req_data[3], clear=5'b01000.
REQ-036 Masking: req_valid=5'b11111, port_mask=5'b10001 -> only inputs 0 and 4 granted, alternating 0,4,0,4.
REQ-037 Wrap: rr_ptr=4, req_valid=5'b10001 -> winner 4, rr_ptr becomes 0; next winner 0.
REQ-038 Reset mid-operation: rst pulsed while out_valid=1, out_ready=0 -> out_valid=0, clear=0, flit_count=0 immediately; no stale clear after release.
